// File: rtl/addsub6_sequencer.sv
// addsub6_sequencer: operand/result controller wrapped around an external
// ripple-carry adder. An add takes one adder pass; a subtract first negates B
// in a pass of its own (~B + 1) and then adds A and -B. Every pass is held for
// SETTLE cycles before its result is captured. SETTLE must be in 1..15.
module addsub6_sequencer #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_s,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int         MSB       = WIDTH - 1;
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, NEG, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, nb_q, nb_d, result_q, result_d;
    logic             sub_q, sub_d, carry_q, carry_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [3:0]       cnt_q, cnt_d;

    // State and datapath registers, synchronous reset to all-zero / IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            nb_q        <= '0;
            sub_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            nb_q        <= nb_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, adder drive and result capture for each pass
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        nb_d        = nb_q;
        sub_d       = sub_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        adder_a     = '0;
        adder_b     = '0;
        in_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    cnt_d   = SETTLE_M1;
                    state_d = sub ? NEG : ADD;
                end
            end
            NEG: begin
                // Two's-complement negate of B; the carry out of this pass is meaningless
                adder_a = ~b_q;
                adder_b = WIDTH'(1);
                if (cnt_q == 4'd0) begin
                    nb_d    = adder_s;
                    cnt_d   = SETTLE_M1;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ADD: begin
                adder_a = a_q;
                adder_b = sub_q ? nb_q : b_q;
                if (cnt_q == 4'd0) begin
                    result_d = adder_s;
                    zero_d   = (adder_s == '0);
                    if (sub_q) begin
                        // A + (-B) carries out exactly when A >= B, except -0 == 0 never carries
                        carry_d = (b_q == '0) ? 1'b0 : ~adder_cout;
                        ovf_d   = (a_q[MSB] != b_q[MSB]) && (adder_s[MSB] != a_q[MSB]);
                    end else begin
                        carry_d = adder_cout;
                        ovf_d   = (a_q[MSB] == b_q[MSB]) && (adder_s[MSB] != a_q[MSB]);
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_addsub6_sequencer.sv
// Bench for addsub6_sequencer: two instances (SETTLE=1 and SETTLE=4) share
// the request/response-ready inputs, each with its own adder model. Expected
// results are queued per instance at accept time; a monitor pops on each
// rising out_valid and checks result, flags and latency.
module tb_addsub6_sequencer;

    logic       clk, reset, in_valid, sub, out_ready;
    logic [5:0] op_a, op_b;

    logic       in_ready1, out_valid1, cout1, carry1, zero1, ovf1;
    logic [5:0] aa1, ab1, s1, result1;
    logic       in_ready4, out_valid4, cout4, carry4, zero4, ovf4;
    logic [5:0] aa4, ab4, s4, result4;

    assign {cout1, s1} = {1'b0, aa1} + {1'b0, ab1};
    assign {cout4, s4} = {1'b0, aa4} + {1'b0, ab4};

    addsub6_sequencer #(.WIDTH(6), .SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .sub(sub), .adder_a(aa1), .adder_b(ab1),
        .adder_s(s1), .adder_cout(cout1), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .carry(carry1), .zero(zero1), .overflow(ovf1));

    addsub6_sequencer #(.WIDTH(6), .SETTLE(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .op_a(op_a), .op_b(op_b), .sub(sub), .adder_a(aa4), .adder_b(ab4),
        .adder_s(s4), .adder_cout(cout4), .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .carry(carry4), .zero(zero4), .overflow(ovf4));

    typedef struct {
        logic [5:0] res;
        logic       c, z, v;
        int         acc, lat;
    } exp_t;

    exp_t q1[$], q4[$];
    int   cyc = 0;
    int   errors = 0, checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " u1 outs"}, int'({out_valid1, result1, carry1, zero1, ovf1, aa1, ab1}), 0);
        chk({tag, " u1 in_ready"}, int'(in_ready1), 1);
        chk({tag, " u4 outs"}, int'({out_valid4, result4, carry4, zero4, ovf4, aa4, ab4}), 0);
        chk({tag, " u4 in_ready"}, int'(in_ready4), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(in_ready1 && in_ready4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle wait timeout", 0, 1);
    endtask

    // Issue one request to both instances; optionally queue its expected
    // response and check the adder drive for every settle cycle.
    task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic s,
                         input logic [5:0] er, input logic ec, input logic ez, input logic ev,
                         input bit push, input bit drv);
        logic [5:0] binv, bneg, ea, eb;
        int         acc;
        binv = ~b;
        bneg = ~b + 6'd1;
        wait_idle();
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        if (push) begin
            q1.push_back('{er, ec, ez, ev, acc, s ? 2 : 1});
            q4.push_back('{er, ec, ez, ev, acc, s ? 8 : 4});
        end
        // Scramble operand inputs: they must have been captured at accept
        op_a = 6'h2a; op_b = 6'h15; sub = ~s;
        if (drv) begin
            for (int i = 0; i < (s ? 8 : 4); i++) begin
                @(negedge clk);
                ea = (s && i < 4) ? binv : a;
                eb = s ? ((i < 4) ? 6'd1 : bneg) : b;
                chk($sformatf("u4 adder_a pass cyc%0d", i), int'(aa4), int'(ea));
                chk($sformatf("u4 adder_b pass cyc%0d", i), int'(ab4), int'(eb));
                if (i < (s ? 2 : 1)) begin
                    ea = (s && i == 0) ? binv : a;
                    eb = s ? ((i == 0) ? 6'd1 : bneg) : b;
                    chk($sformatf("u1 adder_a pass cyc%0d", i), int'(aa1), int'(ea));
                    chk($sformatf("u1 adder_b pass cyc%0d", i), int'(ab1), int'(eb));
                end
            end
        end
    endtask

    task automatic mon_one(input string tag, input logic [5:0] r, input logic c,
                           input logic z, input logic v, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, " unexpected out_valid"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, " result"}, int'(r), int'(e.res));
            chk({tag, " carry/zero/ovf"}, int'({c, z, v}), int'({e.c, e.z, e.v}));
            chk({tag, " latency"}, cyc - e.acc, e.lat);
        end
    endtask

    initial begin
        logic p1, p4;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; sub = 1'b0;
        p1 = 1'b0; p4 = 1'b0;

        // Monitor: check each response as out_valid rises
        fork
            forever begin
                @(negedge clk);
                if (out_valid1 && !p1) mon_one("u1", result1, carry1, zero1, ovf1, q1);
                if (out_valid4 && !p4) mon_one("u4", result4, carry4, zero4, ovf4, q4);
                p1 = out_valid1;
                p4 = out_valid4;
            end
        join_none

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_state("post-reset");

        //     a      b      sub   res    c     z     v
        issue(6'd45, 6'd18, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0, 1, 1);
        issue(6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1, 0);
        issue(6'd63, 6'd1,  1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1, 0);
        issue(6'd31, 6'd1,  1'b0, 6'd32, 1'b0, 1'b0, 1'b1, 1, 0);
        issue(6'd20, 6'd20, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 1, 1);
        issue(6'd5,  6'd9,  1'b1, 6'd60, 1'b1, 1'b0, 1'b0, 1, 1);
        issue(6'd10, 6'd0,  1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(6'd32, 6'd1,  1'b1, 6'd31, 1'b0, 1'b0, 1'b1, 1, 0);

        // Backpressure: hold the result while ignoring new requests
        wait_idle();
        out_ready = 1'b0;
        issue(6'd7, 6'd8, 1'b0, 6'd15, 1'b0, 1'b0, 1'b0, 1, 0);
        begin
            int n = 0;
            while (!out_valid1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("backpressure out_valid timeout", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp u1 out_valid held", int'(out_valid1), 1);
            chk("bp u1 result held", int'({result1, carry1, zero1, ovf1}), int'({6'd15, 3'b000}));
            chk("bp u1 in_ready low", int'(in_ready1), 0);
            op_a = 6'd1; op_b = 6'd1; sub = 1'b0;
            in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release u1 out_valid", int'(out_valid1), 0);
        chk("bp release u1 in_ready", int'(in_ready1), 1);
        chk("bp release u1 result kept", int'(result1), 15);

        // Reset in the negate pass of 5-9: aborted, nothing returned
        issue(6'd5, 6'd9, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("mid-op reset");
        issue(6'd1, 6'd2, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1, 0);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("u1 responses outstanding", q1.size(), 0);
        chk("u4 responses outstanding", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
